// File: rtl/fir_param_stream_if.sv
// rtl/fir_param_stream_if.sv - stream, coefficient and status signals of fir_param_stream
interface fir_param_stream_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 32
);
  localparam int ADDR_W = (TAPS > 2) ? $clog2(TAPS) : 1;

  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] din;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  dout;
  logic                     ovf;

  modport master (
    output clear, in_valid, din, coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid, dout, ovf
  );

  modport slave (
    input  clear, in_valid, din, coef_we, coef_addr, coef_data, coef_commit,
    output out_valid, dout, ovf
  );
endinterface

// File: rtl/fir_param_stream.sv
// rtl/fir_param_stream.sv - parametrised pipelined direct-form FIR, shadow/active coefficient banks
// Optional FIR_SAT_EN: round-half-up, saturate to OUT_W and sticky ovf; otherwise truncate/wrap.
module fir_param_stream #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input logic               clk,
  input logic               rst,
  fir_param_stream_if.slave s_if
);
  localparam int LVL    = $clog2(TAPS);
  localparam int ADDR_W = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + LVL;
  // One guard bit above the accumulator keeps the rounding add from wrapping.
  localparam int EXT_W  = (OUT_W > ACC_W) ? OUT_W : ACC_W + 1;
  localparam logic [ADDR_W:0] TAPS_L = (ADDR_W + 1)'(TAPS);

  function automatic int node_cnt(input int lvl);
    return (TAPS + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [COEF_W-1:0] b);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(b);
    return {{LVL{p[PROD_W-1]}}, p};
  endfunction

  logic signed [DATA_W-1:0] x_q      [TAPS];
  logic signed [COEF_W-1:0] shadow_q [TAPS];
  logic signed [COEF_W-1:0] active_q [TAPS];
  logic signed [ACC_W-1:0]  tree_q   [LVL+1][TAPS];
  logic [LVL+2:0]           vld_q;
  logic signed [EXT_W-1:0]  ext_d;
  logic signed [EXT_W-1:0]  scaled_d;
  logic signed [EXT_W-1:0]  scaled_q;
  logic signed [OUT_W-1:0]  fmt_d;
  logic signed [OUT_W-1:0]  dout_q;
  logic                     out_valid_q;

  // vld_q[0] marks the accept stage; each later bit follows one pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      vld_q <= '0;
    end else if (s_if.clear) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      vld_q <= '0;
    end else begin
      if (s_if.in_valid) begin
        x_q[0] <= s_if.din;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      vld_q <= {vld_q[LVL+1:0], s_if.in_valid};
    end
  end

  // Commit reads shadow_q before this edge's write lands, so a concurrent write misses it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (s_if.coef_commit) begin
        for (int k = 0; k < TAPS; k++) active_q[k] <= shadow_q[k];
      end
      if (s_if.coef_we && ({1'b0, s_if.coef_addr} < TAPS_L)) begin
        shadow_q[s_if.coef_addr] <= s_if.coef_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) tree_q[0][k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) tree_q[0][k] <= mul_ext(x_q[k], active_q[k]);
    end
  end

  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    for (genvar i = 0; i < TAPS; i++) begin : g_node
      if (2 * i + 1 < node_cnt(l - 1)) begin : g_add
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) tree_q[l][i] <= '0;
          else      tree_q[l][i] <= tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
        end
      end else if (2 * i < node_cnt(l - 1)) begin : g_pass
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) tree_q[l][i] <= '0;
          else      tree_q[l][i] <= tree_q[l-1][2*i];
        end
      end else begin : g_idle
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) tree_q[l][i] <= '0;
          else      tree_q[l][i] <= '0;
        end
      end
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [EXT_W-1:0] RND =
    (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  logic [EXT_W-OUT_W:0] hi_bits;
  logic                 clamp_d;
  logic                 ovf_q;

  assign ext_d   = EXT_W'(tree_q[LVL][0]) + RND;
  // In range only when every bit from the OUT_W sign bit upward agrees.
  assign hi_bits = scaled_q[EXT_W-1:OUT_W-1];
  assign clamp_d = !((&hi_bits) || !(|hi_bits));
  assign fmt_d   = !clamp_d ? OUT_W'(scaled_q) :
                   scaled_q[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            ovf_q <= 1'b0;
    else if (!s_if.clear && vld_q[LVL+2] && clamp_d)     ovf_q <= 1'b1;
  end

  assign s_if.ovf = ovf_q;
`else
  assign ext_d    = EXT_W'(tree_q[LVL][0]);
  assign fmt_d    = OUT_W'(scaled_q);
  assign s_if.ovf = 1'b0;
`endif

  assign scaled_d = ext_d >>> SHIFT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scaled_q <= '0;
    else      scaled_q <= scaled_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (s_if.clear) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld_q[LVL+2];
      if (vld_q[LVL+2]) dout_q <= fmt_d;
    end
  end

  assign s_if.out_valid = out_valid_q;
  assign s_if.dout      = dout_q;
endmodule

// File: tb/tb_fir_param_stream.sv
// tb/tb_fir_param_stream.sv - directed self-checking bench for fir_param_stream (default, 16-bit out, SHIFT=2)
module tb_fir_param_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_out;
  logic signed [63:0] exp_v;
  logic signed [63:0] imp_exp [8];

  fir_param_stream_if #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32)) b0 ();
  fir_param_stream_if #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(16)) b1 ();
  fir_param_stream_if #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32)) b2 ();

  fir_param_stream #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32), .SHIFT(0)) u0 (
    .clk(clk), .rst(rst), .s_if(b0.slave));
  fir_param_stream #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(16), .SHIFT(0)) u1 (
    .clk(clk), .rst(rst), .s_if(b1.slave));
  fir_param_stream #(.DATA_W(16), .COEF_W(16), .TAPS(8), .OUT_W(32), .SHIFT(2)) u2 (
    .clk(clk), .rst(rst), .s_if(b2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic b0_write(input int a, input int d);
    b0.coef_we   = 1'b1;
    b0.coef_addr = 3'(a);
    b0.coef_data = 16'(d);
    tick();
    b0.coef_we   = 1'b0;
  endtask

  task automatic b0_commit();
    b0.coef_commit = 1'b1;
    tick();
    b0.coef_commit = 1'b0;
  endtask

  // Impulse then zeros on b0; response should be imp_exp[0..7] starting 6 edges later.
  task automatic run_impulse(input string tag);
    b0.in_valid = 1'b1;
    b0.din      = 16'sd1;
    tick();
    b0.din = 16'sd0;
    for (int t = 1; t <= 16; t++) begin
      if (t >= 9) b0.in_valid = 1'b0;
      tick();
      if (t == 5) check({tag, "_early_valid"}, b0.out_valid, 0);
      if (t >= 6 && t <= 13) begin
        check({tag, "_valid"}, b0.out_valid, 1);
        check({tag, "_dout"}, b0.dout, imp_exp[t-6]);
      end
      if (t == 14) check({tag, "_tail"}, b0.dout, 0);
    end
  endtask

  function automatic longint ramp_ref(input int n);
    longint s = 0;
    for (int k = 0; k < 8; k++) if (n >= k) s += longint'((k + 1) * (n - k + 1));
    return s;
  endfunction

  initial begin
    b0.clear = 0; b0.in_valid = 0; b0.din = '0; b0.coef_we = 0; b0.coef_addr = '0; b0.coef_data = '0; b0.coef_commit = 0;
    b1.clear = 0; b1.in_valid = 0; b1.din = '0; b1.coef_we = 0; b1.coef_addr = '0; b1.coef_data = '0; b1.coef_commit = 0;
    b2.clear = 0; b2.in_valid = 0; b2.din = '0; b2.coef_we = 0; b2.coef_addr = '0; b2.coef_data = '0; b2.coef_commit = 0;
    repeat (3) tick();
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_dout", b0.dout, 0);
    check("rst_ovf", b1.ovf, 0);
    rst = 1'b1;
    tick();

    // impulse with coefs 1..8
    for (int k = 0; k < 8; k++) begin
      b0_write(k, k + 1);
      imp_exp[k] = k + 1;
    end
    b0_commit();
    run_impulse("imp");

    // gapped ramp 1..20
    b0.clear = 1'b1; tick(); b0.clear = 1'b0;
    n_out = 0;
    for (int c = 0; c < 52; c++) begin
      b0.in_valid = (c < 40) && (c % 2 == 0);
      b0.din      = 16'(c / 2 + 1);
      tick();
      if (b0.out_valid) begin
        check("ramp", b0.dout, ramp_ref(n_out));
        n_out++;
      end
    end
    b0.in_valid = 1'b0;
    check("ramp_count", n_out, 20);

    // mid-stream commit with one concurrent write
    b0.clear = 1'b1; tick(); b0.clear = 1'b0;
    for (int k = 0; k < 8; k++) b0_write(k, 1);
    b0_commit();
    n_out = 0;
    for (int c = 0; c < 30; c++) begin
      b0.in_valid    = (c < 20);
      b0.din         = 16'sd100;
      b0.coef_we     = (c >= 2 && c <= 10);
      b0.coef_addr   = (c == 10) ? 3'd0 : 3'(c - 2);
      b0.coef_data   = (c == 10) ? 16'sd5 : 16'sd2;
      b0.coef_commit = (c == 10);
      tick();
      if (b0.out_valid) begin
        exp_v = (n_out < 10) ? 64'(100 * ((n_out + 1 < 8) ? n_out + 1 : 8)) : 64'sd1600;
        check("mid", b0.dout, exp_v);
        n_out++;
      end
    end
    b0.in_valid = 1'b0; b0.coef_we = 1'b0; b0.coef_commit = 1'b0;
    check("mid_count", n_out, 20);
    b0_commit();
    b0.in_valid = 1'b1; b0.din = 16'sd100; tick(); b0.in_valid = 1'b0;
    repeat (5) tick();
    tick();
    check("mid_late_valid", b0.out_valid, 1);
    check("mid_late_dout", b0.dout, 1900);

    // clear with samples in flight, coefs {5,2,...} retained
    b0.in_valid = 1'b1; b0.din = 16'sd7;
    repeat (3) tick();
    b0.clear = 1'b1; b0.din = 16'sd9; tick();
    b0.clear = 1'b0; b0.in_valid = 1'b0;
    n_out = 0;
    repeat (10) begin
      tick();
      if (b0.out_valid) n_out++;
    end
    check("clear_flush", n_out, 0);
    check("clear_dout_hold", b0.dout, 1900);
    imp_exp[0] = 5;
    for (int k = 1; k < 8; k++) imp_exp[k] = 2;
    run_impulse("clr_imp");

    // saturation on 16-bit output
    for (int k = 0; k < 8; k++) begin
      b1.coef_we = 1'b1; b1.coef_addr = 3'(k); b1.coef_data = 16'sd32767;
      tick();
    end
    b1.coef_we = 1'b0;
    b1.coef_commit = 1'b1; tick(); b1.coef_commit = 1'b0;
    b1.in_valid = 1'b1; b1.din = 16'sd32767;
    for (int t = 0; t < 16; t++) begin
      if (t == 12) b1.in_valid = 1'b0;
      tick();
      if (t == 5) begin
        check("sat_early_valid", b1.out_valid, 0);
        check("sat_early_ovf", b1.ovf, 0);
      end
`ifdef FIR_SAT_EN
      if (t == 6)  begin check("sat_first", b1.dout, 32767); check("sat_first_ovf", b1.ovf, 1); end
      if (t == 13) begin check("sat_full", b1.dout, 32767);  check("sat_full_ovf", b1.ovf, 1); end
`else
      if (t == 6)  begin check("wrap_first", b1.dout, 1); check("wrap_first_ovf", b1.ovf, 0); end
      if (t == 13) begin check("wrap_full", b1.dout, 8); check("wrap_full_ovf", b1.ovf, 0); end
`endif
    end

    // rounding with SHIFT=2, single tap
    b2.coef_we = 1'b1; b2.coef_addr = 3'd0; b2.coef_data = 16'sd1; tick();
    b2.coef_we = 1'b0;
    b2.coef_commit = 1'b1; tick(); b2.coef_commit = 1'b0;
    b2.in_valid = 1'b1; b2.din = 16'sd6; tick();
    b2.din = -16'sd6; tick();
    b2.in_valid = 1'b0;
    repeat (4) tick();
    tick();
    check("rnd_pos_valid", b2.out_valid, 1);
`ifdef FIR_SAT_EN
    check("rnd_pos", b2.dout, 2);
    tick();
    check("rnd_neg", b2.dout, -1);
`else
    check("trunc_pos", b2.dout, 1);
    tick();
    check("trunc_neg", b2.dout, -2);
`endif

    // reset with samples in flight
    b0.in_valid = 1'b1; b0.din = 16'sd50;
    repeat (3) tick();
    b0.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_out_valid", b0.out_valid, 0);
    check("mrst_dout", b0.dout, 0);
    check("mrst_ovf", b1.ovf, 0);
    n_out = 0;
    repeat (10) begin
      tick();
      if (b0.out_valid) n_out++;
    end
    check("mrst_no_pulses", n_out, 0);
    b0_commit();
    for (int k = 0; k < 8; k++) imp_exp[k] = 0;
    run_impulse("mrst_imp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
